bridge_out_serializer: RTL

//   Output end of the DRAM<->SD bridge: takes each 64-bit transfer word produced by the DRAM/SD datapath
//   and drives it to the checker as 8 consecutive out_valid beats, one byte per beat, MSB byte first.

---
 rtl/bridge_ser_pkg.sv | 21 ++
 rtl/ser_fifo.sv | 52 +++++
 rtl/bridge_out_serializer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/bridge_ser_pkg.sv
// Shared types and widths for the bridge output serializer.
package bridge_ser_pkg;

  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned BYTES      = DATA_W_DEF / 8;
  localparam int unsigned BYTE_CNT_W = $clog2(BYTES);
  localparam int unsigned GAP_CNT_W  = 4;
  localparam int unsigned WORD_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    GAP_W = 2'd2
  } ser_state_t;

  // Counter width for a range of n values, never below one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ser_fifo.sv
// Synchronous word FIFO buffering transfer words ahead of the serializer.
module ser_fifo
  import bridge_ser_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_W-1:0]             wdata,
  output logic [DATA_W-1:0]             head_c,
  output logic                          full_c,
  output logic                          empty_c,
  output logic [cnt_w(DEPTH):0]         count
);

  localparam int unsigned AW = cnt_w(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full_c  = (count == CW'(DEPTH));
  assign empty_c = (count == '0);
  assign head_c  = mem[rd_ptr];
  assign do_push = push & ~full_c;
  assign do_pop  = pop & ~empty_c;

  // Word storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/bridge_out_serializer.sv
// Serializes buffered transfer words into 8-bit beats, MSB byte first,
// with a fixed idle gap between bursts. Optional macro SER_STAT_EN adds
// a word_cnt port counting fully sent words.
module bridge_out_serializer
  import bridge_ser_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned GAP    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [7:0]            out_data
`ifdef SER_STAT_EN
  ,
  output logic [WORD_CNT_W-1:0] word_cnt
`endif
);

  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned BCW    = cnt_w(NBYTES);
  localparam int unsigned CW     = cnt_w(DEPTH) + 1;
  localparam int unsigned GCW    = GAP_CNT_W;

  ser_state_t        state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
  logic [GCW-1:0]    gap_cnt_q, gap_cnt_d;
  logic              out_valid_d;
  logic [7:0]        out_data_d;
  logic              load_c;
  logic              pop_c;
  logic              push_c;
  logic [DATA_W-1:0] head_c;
  logic              full_c;
  logic              empty_c;
  logic [CW-1:0]     count;
  logic [CW-1:0]     cnt_nxt_c;

  assign push_c    = in_valid & in_ready & ~full_c;
  assign cnt_nxt_c = count + CW'(push_c) - CW'(pop_c);

  ser_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_c),
    .pop     (pop_c),
    .wdata   (in_data),
    .head_c  (head_c),
    .full_c  (full_c),
    .empty_c (empty_c),
    .count   (count)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and next-output decode; a load pops the head and emits its top byte.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    byte_cnt_d  = byte_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    out_valid_d = 1'b0;
    out_data_d  = 8'h00;
    load_c      = 1'b0;
    pop_c       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_c) load_c = 1'b1;
      end
      SEND: begin
        if (byte_cnt_q == BCW'(NBYTES - 1)) begin
          state_d   = GAP_W;
          gap_cnt_d = GCW'(1);
        end else begin
          shreg_d     = shreg_q << 8;
          byte_cnt_d  = byte_cnt_q + BCW'(1);
          out_valid_d = 1'b1;
          out_data_d  = shreg_q[DATA_W-9 -: 8];
        end
      end
      GAP_W: begin
        if (gap_cnt_q == GCW'(GAP)) begin
          if (!empty_c) load_c = 1'b1;
          else          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (load_c) begin
      pop_c       = 1'b1;
      shreg_d     = head_c;
      byte_cnt_d  = '0;
      out_valid_d = 1'b1;
      out_data_d  = head_c[DATA_W-1 -: 8];
      state_d     = SEND;
    end
  end

  // Datapath, counters and registered outputs; in_ready tracks the post-edge fill level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q    <= '0;
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
      in_ready   <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      out_valid  <= out_valid_d;
      out_data   <= out_data_d;
      in_ready   <= (cnt_nxt_c != CW'(DEPTH));
    end
  end

`ifdef SER_STAT_EN
  // Count words whose last beat ends on this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
    end else if (state_q == SEND && byte_cnt_q == BCW'(NBYTES - 1)) begin
      word_cnt <= word_cnt + WORD_CNT_W'(1);
    end
  end
`endif

endmodule
